// File: rtl/dmem_wait.sv
// Word-organised data memory with a req/ready handshake and a programmable number of wait states.
// An access completes WAIT_STATES+1 cycles after acceptance; stall freezes the core meanwhile.
module dmem_wait #(
  parameter int WORDS       = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] address,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int         AW = $clog2(WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [3:0]    be_r;
  logic [31:2]   addr_r;
  logic [31:0]   wd_r;
  logic [31:0]   mem_r [WORDS];

  logic          acc_s;
  logic          acc_we_s;
  logic [3:0]    acc_be_s;
  logic [31:2]   acc_addr_s;
  logic [31:0]   acc_wd_s;
  logic          in_range_s;
  logic [AW-1:0] idx_s;
  logic          mem_we_s;
  logic [31:0]   merged_s;
  logic          unused_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lanes[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // Select the operands of the access completing this cycle (live inputs when there are no wait states)
  always_comb begin
    acc_s      = 1'b0;
    acc_we_s   = we_r;
    acc_be_s   = be_r;
    acc_addr_s = addr_r;
    acc_wd_s   = wd_r;
    case (state_r)
      IDLE: begin
        if (req && (WS == 4'd0)) begin
          acc_s      = 1'b1;
          acc_we_s   = we;
          acc_be_s   = be;
          acc_addr_s = address[31:2];
          acc_wd_s   = wd;
        end else begin
          acc_s = 1'b0;
        end
      end
      BUSY:    acc_s = (cnt_r == 4'd0);
      default: acc_s = 1'b0;
    endcase
  end

  assign in_range_s = (acc_addr_s[31:AW+2] == {(30-AW){1'b0}});
  assign idx_s      = acc_addr_s[AW+1:2];
  assign mem_we_s   = acc_s & acc_we_s & in_range_s & reset;
  assign merged_s   = merge_lanes(mem_r[idx_s], acc_wd_s, acc_be_s);
  assign stall      = req & ~ready;
  // Byte offset is deliberately ignored; lane selection is carried by be alone.
  assign unused_s   = ^address[1:0];

  // Handshake FSM: request capture, wait-state countdown and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      be_r    <= 4'd0;
      addr_r  <= 30'd0;
      wd_r    <= 32'd0;
      rd      <= 32'd0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready <= 1'b0;
          if (req) begin
            we_r    <= we;
            be_r    <= be;
            addr_r  <= address[31:2];
            wd_r    <= wd;
            cnt_r   <= (WS == 4'd0) ? 4'd0 : (WS - 4'd1);
            state_r <= (WS == 4'd0) ? RESP : BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= RESP;
          end
        end
        RESP: begin
          ready   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      if (acc_s) begin
        ready <= 1'b1;
        err   <= ~in_range_s;
        if (!acc_we_s) begin
          rd <= in_range_s ? mem_r[idx_s] : 32'd0;
        end
      end
    end
  end

  // Storage array: no reset, written only by an in-range access that completes
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

endmodule
